// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_pkg
//  Description : Shared CPU definitions for the multicycle divider: datapath
//                width defaults, divider FSM state encoding and the
//                divide-by-zero exception cause code.
//  Revision    : 1.0  initial release
// ============================================================================
package div_unit_pkg;

    // Default operand/result width and the iteration-counter width
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    // Divider FSM state encoding
    typedef logic [1:0] div_state_t;

    localparam div_state_t DIV_IDLE = 2'd0;
    localparam div_state_t DIV_CALC = 2'd1;
    localparam div_state_t DIV_FIX  = 2'd2;

    // Exception cause raised by the control unit on a div_zero pulse
    localparam logic [4:0] EXC_DIV_ZERO = 5'h0F;

endpackage : div_unit_pkg
`default_nettype wire

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_if
//  Description : Request/result bundle between the control unit (master) and
//                the multicycle divider (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             div_start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] lo_out;
    logic [WIDTH-1:0] hi_out;
    logic             div_done;
    logic             div_zero;
    logic             busy;

    // Control unit side: issues requests, consumes results and status
    modport master (
        output div_start,
        output dividend,
        output divisor,
        input  lo_out,
        input  hi_out,
        input  div_done,
        input  div_zero,
        input  busy
    );

    // Divider side
    modport slave (
        input  div_start,
        input  dividend,
        input  divisor,
        output lo_out,
        output hi_out,
        output div_done,
        output div_zero,
        output busy
    );

endinterface : div_unit_if
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Multicycle signed divider (MIPS DIV semantics). Restoring
//                division on operand magnitudes, one quotient bit per clock,
//                followed by a single sign-correction cycle. Quotient goes to
//                LO, remainder to HI; divide-by-zero raises div_zero instead.
//  Revision    : 1.0  initial release
// ============================================================================
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  wire          clk,
    input  wire          reset,     // asynchronous, active low
    div_unit_if.slave    bus
);

    // Counter value on the final restoring step
    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(WIDTH - 1);

    div_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_rem;       // partial remainder (always < divisor)
    logic [WIDTH-1:0]  r_quot;      // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0]  r_dvsr;      // divisor magnitude
    logic              r_sign_q;
    logic              r_sign_r;
    logic [WIDTH-1:0]  r_lo;
    logic [WIDTH-1:0]  r_hi;
    logic              r_done;
    logic              r_zero;

    logic [WIDTH-1:0]  w_dvd_mag;
    logic [WIDTH-1:0]  w_dvs_mag;
    logic [WIDTH:0]    w_shift;     // remainder shifted left with next dividend bit
    logic [WIDTH:0]    w_trial;     // shifted remainder minus divisor, 33-bit

    // Operand magnitudes and the trial subtraction for the current step.
    // The magnitude of the most negative value is its own unsigned pattern,
    // which is exactly what the restoring loop needs.
    always_comb begin
        w_dvd_mag = bus.dividend[WIDTH-1] ? (-bus.dividend) : bus.dividend;
        w_dvs_mag = bus.divisor[WIDTH-1]  ? (-bus.divisor)  : bus.divisor;
        w_shift   = {r_rem, r_quot[WIDTH-1]};
        w_trial   = w_shift - {1'b0, r_dvsr};
    end

    // Divider FSM and datapath: accept in IDLE, iterate in CALC, sign-fix in FIX
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= DIV_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_dvsr   <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_done   <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_zero <= 1'b0;
            case (r_state)
                DIV_IDLE: begin
                    if (bus.div_start) begin
                        if (bus.divisor == '0) begin
                            // Exception request only; results are left untouched
                            r_zero <= 1'b1;
                        end else begin
                            r_quot   <= w_dvd_mag;
                            r_dvsr   <= w_dvs_mag;
                            r_sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            r_sign_r <= bus.dividend[WIDTH-1];
                            r_rem    <= '0;
                            r_cnt    <= '0;
                            r_state  <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    // Keep the trial difference when non-negative, otherwise restore
                    if (w_trial[WIDTH]) begin
                        r_rem <= w_shift[WIDTH-1:0];
                    end else begin
                        r_rem <= w_trial[WIDTH-1:0];
                    end
                    r_quot <= {r_quot[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_last_step) begin
                        r_state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    // Quotient truncates toward zero, remainder follows the dividend.
                    // -2^31 / -1 wraps back to 0x80000000 with no exception.
                    r_lo    <= r_sign_q ? (-r_quot) : r_quot;
                    r_hi    <= r_sign_r ? (-r_rem)  : r_rem;
                    r_done  <= 1'b1;
                    r_state <= DIV_IDLE;
                end
                default: begin
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign bus.lo_out   = r_lo;
    assign bus.hi_out   = r_hi;
    assign bus.div_done = r_done;
    assign bus.div_zero = r_zero;
    assign bus.busy     = (r_state == DIV_CALC) || (r_state == DIV_FIX);

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Scoreboard testbench for div_unit. Stimulus pushes the
//                hand-computed expected result (and the clock edge it should
//                appear after); a monitor pops on every div_done / div_zero.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          is_zero;
        logic [31:0] lo;
        logic [31:0] hi;
        int          at_edge;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Rising-edge counter used for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every result or exception pulse must match the oldest expectation
    initial begin
        forever begin
            @(negedge clk);
            if (reset && (bus.div_done || bus.div_zero)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {30'd0, bus.div_zero, bus.div_done}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("div_zero", {31'd0, bus.div_zero}, {31'd0, e.is_zero});
                    chk("div_done", {31'd0, bus.div_done}, {31'd0, !e.is_zero});
                    chk("lo_out", bus.lo_out, e.lo);
                    chk("hi_out", bus.hi_out, e.hi);
                    chk("latency_edge", cyc, e.at_edge);
                end
            end
        end
    end

    // Drive one request at a falling edge; optionally record its expected outcome
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push,
                         input logic [31:0] lo, input logic [31:0] hi);
        exp_t e;
        bus.div_start = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        if (push) begin
            e.is_zero = (b == 32'd0);
            e.lo      = lo;
            e.hi      = hi;
            e.at_edge = cyc + 1 + ((b == 32'd0) ? 0 : 33);
            sb.push_back(e);
        end
        @(negedge clk);
        bus.div_start = 1'b0;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
    endtask

    // Wait (bounded) until every pending expectation has been observed
    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            chk({name, "_timeout"}, sb.size(), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int g;

        bus.div_start = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_lo", bus.lo_out, 32'd0);
        chk("rst_hi", bus.hi_out, 32'd0);
        chk("rst_done", {31'd0, bus.div_done}, 32'd0);
        chk("rst_zero", {31'd0, bus.div_zero}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 100 / 7 with busy-window measurement
        issue(32'd100, 32'd7, 1'b1, 32'd14, 32'd2);
        cnt = 0;
        g   = 0;
        while (!bus.div_done && g < 100) begin
            if (bus.busy) cnt++;
            @(negedge clk);
            g++;
        end
        chk("busy_cycles", cnt, 32'd33);
        chk("busy_in_done_cycle", {31'd0, bus.busy}, 32'd0);
        drain("pos_pos");

        // Sign combinations
        issue(-32'sd100, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        drain("neg_pos");
        issue(32'd100, -32'sd7, 1'b1, 32'hFFFF_FFF2, 32'd2);
        drain("pos_neg");
        issue(-32'sd100, -32'sd7, 1'b1, 32'd14, 32'hFFFF_FFFE);
        drain("neg_neg");

        // Overflow wrap, small / zero dividends, largest positive
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
        drain("overflow");
        issue(32'd0, 32'd5, 1'b1, 32'd0, 32'd0);
        drain("zero_dividend");
        issue(32'd5, 32'd7, 1'b1, 32'd0, 32'd5);
        drain("small_pos");
        issue(-32'sd5, 32'd7, 1'b1, 32'd0, 32'hFFFF_FFFB);
        drain("small_neg");

        // Divide by zero after a 100/7 result, then an immediate follow-up
        issue(32'd100, 32'd7, 1'b1, 32'd14, 32'd2);
        drain("pre_zero");
        issue(32'd55, 32'd0, 1'b1, 32'd14, 32'd2);
        chk("busy_after_zero", {31'd0, bus.busy}, 32'd0);
        issue(32'd9, 32'd3, 1'b1, 32'd3, 32'd0);
        drain("zero_then_9_3");

        // Start while busy is ignored
        issue(32'd1000, 32'd10, 1'b1, 32'd100, 32'd0);
        repeat (9) @(negedge clk);
        chk("busy_mid_op", {31'd0, bus.busy}, 32'd1);
        issue(32'd5, 32'd1, 1'b0, 32'd0, 32'd0);
        drain("ignored_start");

        // Start accepted in the div_done cycle
        issue(32'd7, 32'd2, 1'b1, 32'd3, 32'd1);
        g = 0;
        while (!bus.div_done && g < 100) begin
            @(negedge clk);
            g++;
        end
        issue(32'h7FFF_FFFF, 32'd2, 1'b1, 32'h3FFF_FFFF, 32'd1);
        drain("back_to_back");

        // Asynchronous reset mid-operation
        issue(32'd1000, 32'd10, 1'b1, 32'd100, 32'd0);
        repeat (11) @(negedge clk);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("arst_lo", bus.lo_out, 32'd0);
        chk("arst_hi", bus.hi_out, 32'd0);
        chk("arst_done", {31'd0, bus.div_done}, 32'd0);
        chk("arst_zero", {31'd0, bus.div_zero}, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(32'd7, 32'd2, 1'b1, 32'd3, 32'd1);
        drain("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_div_unit
`default_nettype wire
